regstat_ckpt_ctrl: RTL and testbench

REGSTAT_CKPT_CTRL -- requirements
Module: regstat_ckpt_ctrl

---
 rtl/regstat_ckpt_ctrl.sv | 114 +++++++++++
 tb/tb_regstat_ckpt_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regstat_ckpt_ctrl.sv
// Branch checkpoint controller: circular buffer of {ROB tag, busy snapshot} with a one-cycle restore FSM.
// Optional sticky ckptMiss flag is built when REGSTAT_CKPT_MISS_EN is defined.
module regstat_ckpt_ctrl #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2,
  parameter int CKPT  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   snapValid,
  input  logic [ROB:0]           snapROB,
  input  logic [WIDTH:0]         regStatusSnap,
  input  logic                   commitValid,
  input  logic [ROB:0]           commitROB,
  input  logic                   mispredict,
  input  logic [ROB:0]           mispredictROB,
  output logic [WIDTH:0]         statusRestore,
  output logic                   restore,
  output logic                   stall,
  output logic [$clog2(CKPT):0]  ckptCount
`ifdef REGSTAT_CKPT_MISS_EN
  ,
  output logic                   ckptMiss
`endif
);

  localparam int PW = $clog2(CKPT);
  localparam logic [PW:0] FULLC = (PW+1)'(CKPT);
  localparam logic [PW:0] ONE   = (PW+1)'(1);

  typedef enum logic {IDLE, RESTORE} state_t;
  state_t state, state_nxt;

  logic [ROB:0]   tag_q  [CKPT];
  logic [WIDTH:0] snap_q [CKPT];
  logic [PW:0]    head, tail, count;
  logic           full, commit_free, do_alloc, do_rest;
  logic           hit;
  logic [PW:0]    hit_ptr, p;
  logic [WIDTH:0] hit_snap;

  assign count       = tail - head;
  assign full        = (count == FULLC);
  assign commit_free = commitValid && (count != '0) && (tag_q[head[PW-1:0]] == commitROB);

  // Oldest-first search: first live slot from head whose tag matches.
  always_comb begin
    hit      = 1'b0;
    hit_ptr  = head;
    hit_snap = '0;
    p        = head;
    for (int i = 0; i < CKPT; i++) begin
      p = head + (PW+1)'(i);
      if (!hit && ((PW+1)'(i) < count) && (tag_q[p[PW-1:0]] == mispredictROB)) begin
        hit      = 1'b1;
        hit_ptr  = p;
        hit_snap = snap_q[p[PW-1:0]];
      end
    end
  end

  assign do_rest  = (state == IDLE) && mispredict && hit;
  assign do_alloc = (state == IDLE) && snapValid && !mispredict && !full;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (do_rest) state_nxt = RESTORE;
      RESTORE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign restore   = (state == RESTORE);
  assign stall     = full || restore;
  assign ckptCount = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      head          <= '0;
      tail          <= '0;
      statusRestore <= '0;
    end else begin
      state <= state_nxt;
      if (commit_free) head <= head + ONE;
      if (do_rest) begin
        // Matched slot is also being committed: tail must follow the advanced head.
        tail          <= (commit_free && hit_ptr == head) ? head + ONE : hit_ptr;
        statusRestore <= hit_snap;
      end else if (do_alloc) begin
        tail <= tail + ONE;
      end
    end
  end

  // Storage needs no reset: only slots between head and tail are read.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      tag_q[tail[PW-1:0]]  <= snapROB;
      snap_q[tail[PW-1:0]] <= regStatusSnap;
    end
  end

`ifdef REGSTAT_CKPT_MISS_EN
  always_ff @(posedge clk) begin
    if (reset)
      ckptMiss <= 1'b0;
    else if ((state == IDLE) && mispredict && !hit)
      ckptMiss <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_regstat_ckpt_ctrl.sv
// Bench for regstat_ckpt_ctrl: directed vector table, wrap sequence, and random run vs a queue model.
module tb_regstat_ckpt_ctrl;
  localparam int CKPT = 4;

  logic        clk, reset, snapValid, commitValid, mispredict;
  logic [2:0]  snapROB, commitROB, mispredictROB;
  logic [31:0] regStatusSnap, statusRestore;
  logic        restore, stall;
  logic [2:0]  ckptCount;
`ifdef REGSTAT_CKPT_MISS_EN
  logic        ckptMiss;
`endif

  int checks = 0;
  int errors = 0;

  regstat_ckpt_ctrl #(.WIDTH(31), .ROB(2), .CKPT(CKPT)) dut (
    .clk(clk), .reset(reset), .snapValid(snapValid), .snapROB(snapROB),
    .regStatusSnap(regStatusSnap), .commitValid(commitValid), .commitROB(commitROB),
    .mispredict(mispredict), .mispredictROB(mispredictROB),
    .statusRestore(statusRestore), .restore(restore), .stall(stall), .ckptCount(ckptCount)
`ifdef REGSTAT_CKPT_MISS_EN
    , .ckptMiss(ckptMiss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst, sv; logic [2:0] st; logic [31:0] ss;
    logic cv; logic [2:0] ct; logic mp; logic [2:0] mt;
    int cnt; logic rs, stl; logic [31:0] sr; logic miss;
  } vec_t;
  vec_t tbl[$];

  typedef struct { logic [2:0] tag; logic [31:0] snap; } ent_t;
  ent_t mq[$];
  bit          m_rest, m_miss;
  logic [31:0] m_sr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic rst, logic sv, logic [2:0] st, logic [31:0] ss,
                              logic cv, logic [2:0] ct, logic mp, logic [2:0] mt,
                              int cnt, logic rs, logic stl, logic [31:0] sr, logic miss);
    vec_t v;
    v.rst = rst; v.sv = sv; v.st = st; v.ss = ss; v.cv = cv; v.ct = ct; v.mp = mp; v.mt = mt;
    v.cnt = cnt; v.rs = rs; v.stl = stl; v.sr = sr; v.miss = miss;
    return v;
  endfunction

  task automatic drive(logic rst, logic sv, logic [2:0] st, logic [31:0] ss,
                       logic cv, logic [2:0] ct, logic mp, logic [2:0] mt);
    reset = rst; snapValid = sv; snapROB = st; regStatusSnap = ss;
    commitValid = cv; commitROB = ct; mispredict = mp; mispredictROB = mt;
  endtask

  // Reference: a queue of live checkpoints, oldest first; applied to current inputs.
  task automatic model_step();
    int  n, fi;
    bit  cfree, found;
    ent_t e;
    if (reset) begin
      mq.delete(); m_rest = 0; m_sr = '0; m_miss = 0;
      return;
    end
    n = mq.size();
    cfree = commitValid && n > 0 && mq[0].tag == commitROB;
    found = 0; fi = 0;
    if (!m_rest && mispredict) begin
      for (int i = 0; i < n; i++)
        if (!found && mq[i].tag == mispredictROB) begin found = 1; fi = i; end
      if (!found) m_miss = 1;
    end
    if (found) begin
      m_sr = mq[fi].snap;
      while (mq.size() > fi) void'(mq.pop_back());
    end
    if (cfree && mq.size() > 0) void'(mq.pop_front());
    if (!m_rest && !mispredict && snapValid && n < CKPT) begin
      e.tag = snapROB; e.snap = regStatusSnap;
      mq.push_back(e);
    end
    m_rest = found;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    //             rst sv st ss        cv ct mp mt  cnt rs stl sr        miss
    tbl.push_back(mk(1, 0, 0, 32'h0,   0, 0, 0, 0,  0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 1, 1, 32'h1,   0, 0, 0, 0,  1, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 1, 2, 32'h2,   0, 0, 0, 0,  2, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 1, 3, 32'h4,   0, 0, 0, 0,  3, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 1, 4, 32'h8,   0, 0, 0, 0,  4, 0, 1, 32'h0,  0));
    tbl.push_back(mk(0, 1, 5, 32'h10,  0, 0, 0, 0,  4, 0, 1, 32'h0,  0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 2,  1, 1, 1, 32'h2,  0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0, 0,  1, 0, 0, 32'h2,  0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 1, 0, 0,  0, 0, 0, 32'h2,  0));
    tbl.push_back(mk(0, 1, 5, 32'h20,  0, 0, 0, 0,  1, 0, 0, 32'h2,  0));
    tbl.push_back(mk(0, 1, 6, 32'h40,  0, 0, 0, 0,  2, 0, 0, 32'h2,  0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 5, 1, 6,  0, 1, 1, 32'h40, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0, 0,  0, 0, 0, 32'h40, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 3,  0, 0, 0, 32'h40, 1));
    tbl.push_back(mk(0, 1, 7, 32'h80,  0, 0, 0, 0,  1, 0, 0, 32'h40, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 7,  0, 1, 1, 32'h80, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,   0, 0, 0, 0,  0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0, 0,  0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 1, 2, 32'h9,   0, 0, 1, 5,  0, 0, 0, 32'h0,  1));
    tbl.push_back(mk(0, 1, 1, 32'h3,   0, 0, 0, 0,  1, 0, 0, 32'h0,  1));
    tbl.push_back(mk(0, 1, 2, 32'h5,   0, 0, 0, 0,  2, 0, 0, 32'h0,  1));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 2,  1, 1, 1, 32'h5,  1));
    tbl.push_back(mk(0, 1, 4, 32'h77,  1, 1, 1, 1,  0, 0, 0, 32'h5,  1));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].sv, tbl[i].st, tbl[i].ss, tbl[i].cv, tbl[i].ct, tbl[i].mp, tbl[i].mt);
      @(posedge clk); #1;
      chk($sformatf("vec%0d ckptCount", i), 32'(ckptCount), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d restore", i), 32'(restore), 32'(tbl[i].rs));
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(tbl[i].stl));
      chk($sformatf("vec%0d statusRestore", i), statusRestore, tbl[i].sr);
`ifdef REGSTAT_CKPT_MISS_EN
      chk($sformatf("vec%0d ckptMiss", i), 32'(ckptMiss), 32'(tbl[i].miss));
`endif
    end

    // Alloc/commit pairs wrapping the buffer three times.
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); drive(0, 1, 3'(k), 32'(1) << k, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk($sformatf("wrap%0d alloc count", k), 32'(ckptCount), 32'd1);
      @(negedge clk); drive(0, 0, 0, 0, 1, 3'(k), 0, 0);
      @(posedge clk); #1;
      chk($sformatf("wrap%0d commit count", k), 32'(ckptCount), 32'd0);
    end

    // Random run against the queue model.
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0); model_step();
    @(posedge clk); #1;
    for (int c = 0; c < 1500; c++) begin
      logic [2:0] ct, mt;
      @(negedge clk);
      ct = (mq.size() > 0 && $urandom_range(3) != 0) ? mq[0].tag : 3'($urandom_range(7));
      mt = (mq.size() > 0 && $urandom_range(2) != 0) ? mq[$urandom_range(mq.size()-1)].tag
                                                      : 3'($urandom_range(7));
      drive($urandom_range(99) == 0, 1'($urandom_range(1)), 3'($urandom_range(7)), $urandom,
            1'($urandom_range(1)), ct, $urandom_range(6) == 0, mt);
      model_step();
      @(posedge clk); #1;
      chk("rand ckptCount", 32'(ckptCount), 32'(mq.size()));
      chk("rand restore", 32'(restore), 32'(m_rest));
      chk("rand stall", 32'(stall), 32'((mq.size() == CKPT) || m_rest));
      chk("rand statusRestore", statusRestore, m_sr);
`ifdef REGSTAT_CKPT_MISS_EN
      chk("rand ckptMiss", 32'(ckptMiss), 32'(m_miss));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
